// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator datapath blocks.
//   WORD_W             : width of one FP32 word
//   ofm_reader_state_e : control states of the output feature-map reader
//   FP32_ZERO          : IEEE-754 +0.0 bit pattern
package cnn_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ofm_reader_state_e;

  localparam logic [WORD_W-1:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/ofm_skid_fifo.sv
// Two-entry FIFO that decouples the buffer read pipeline from the output stream.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata   : write strobe and word
//   pop, rdata    : read strobe and head word (rdata valid while !empty)
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..2
module ofm_skid_fifo #(
  parameter int WIDTH_p = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH_p-1:0] wdata,
  input  logic               pop,
  output logic [WIDTH_p-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [WIDTH_p-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset: entries are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/ofm_reader.sv
// Output feature-map reader: walks the M_p x R_p x C_p output buffer (c fastest,
// then r, then m) through a 1-cycle-latency synchronous read port and streams the
// words on a valid/ready interface, flagging the final word with last_o.
// Optional build macro OFM_RELU_EN: words with the sign bit set are replaced by
// +0.0 as they enter the output FIFO; otherwise data is passed bit-exact.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   start_i          : begin readout (only honoured in IDLE)
//   rd_en_o, rd_addr_o, rd_data_i : buffer read port (data one cycle after rd_en_o)
//   data_o, valid_o, ready_i, last_o : output stream
//   busy_o           : not IDLE
//   done_o           : one-cycle completion pulse
module ofm_reader
  import cnn_pkg::*;
#(
  parameter int M_p      = 4,
  parameter int R_p      = 16,
  parameter int C_p      = 16,
  parameter int W_p      = WORD_W,
  parameter int ADDR_W_p = $clog2(M_p*R_p*C_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  output logic                rd_en_o,
  output logic [ADDR_W_p-1:0] rd_addr_o,
  input  logic [W_p-1:0]      rd_data_i,
  output logic [W_p-1:0]      data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int M_W = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int R_W = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int C_W = (C_p > 1) ? $clog2(C_p) : 1;
  localparam logic [M_W-1:0] M_LAST = M_W'(M_p - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(R_p - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(C_p - 1);

  function automatic logic [W_p-1:0] rectify(input logic [W_p-1:0] w);
`ifdef OFM_RELU_EN
    // Any word with the sign bit set (negatives, -0.0, negative NaN) clamps to +0.0.
    return w[W_p-1] ? W_p'(FP32_ZERO) : w;
`else
    return w;
`endif
  endfunction

  ofm_reader_state_e state, state_nxt;

  logic [M_W-1:0] m_cnt;
  logic [R_W-1:0] r_cnt;
  logic [C_W-1:0] c_cnt;
  logic           final_addr;
  logic           issue;
  logic           pop;
  logic [2:0]     pending;

  logic           vld_p1;
  logic           last_p1;

  logic [W_p:0]   fifo_wdata;
  logic [W_p:0]   fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [1:0]     fifo_count;
  logic           fifo_push;

  assign final_addr = (m_cnt == M_LAST) && (r_cnt == R_LAST) && (c_cnt == C_LAST);
  assign pop        = !fifo_empty && ready_i;

  // Words already buffered plus the read still in flight, with this cycle's pop
  // already credited; a new read is allowed only if that leaves a free slot.
  assign pending = {1'b0, fifo_count} + {2'b0, vld_p1} - {2'b0, pop};
  assign issue   = (state == READ) && (pending < 3'd2);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      m_cnt   <= '0;
      r_cnt   <= '0;
      c_cnt   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= issue;
      last_p1 <= issue && final_addr;
      if (state == IDLE && start_i) begin
        m_cnt <= '0;
        r_cnt <= '0;
        c_cnt <= '0;
      end else if (issue) begin
        if (c_cnt == C_LAST) begin
          c_cnt <= '0;
          if (r_cnt == R_LAST) begin
            r_cnt <= '0;
            m_cnt <= (m_cnt == M_LAST) ? '0 : m_cnt + M_W'(1);
          end else begin
            r_cnt <= r_cnt + R_W'(1);
          end
        end else begin
          c_cnt <= c_cnt + C_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = READ;
      READ:    if (issue && final_addr) state_nxt = DRAIN;
      DRAIN:   if (pop && fifo_rdata[W_p]) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: buffer word returns, enters FIFO with its last flag ----
  // The push guard never trips in normal operation (issue gating keeps a slot
  // free); it keeps the FIFO pointers consistent if that invariant were broken.
  assign fifo_push  = vld_p1 && (!fifo_full || pop);
  assign fifo_wdata = {last_p1, rectify(rd_data_i)};

  ofm_skid_fifo #(
    .WIDTH_p(W_p + 1)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---- stage p2: FIFO head drives the stream ----
  always_comb begin
    rd_en_o   = issue;
    rd_addr_o = ADDR_W_p'(int'(m_cnt) * (R_p * C_p) + int'(r_cnt) * C_p + int'(c_cnt));
    valid_o   = !fifo_empty;
    data_o    = '0;
    last_o    = 1'b0;
    if (!fifo_empty) begin
      data_o = fifo_rdata[W_p-1:0];
      last_o = fifo_rdata[W_p];
    end
    busy_o = (state != IDLE);
    done_o = (state == FIN);
  end

endmodule

// File: tb/tb_ofm_reader.sv
module tb_ofm_reader;

  localparam int M = 2;
  localparam int R = 2;
  localparam int C = 3;
  localparam int T = M * R * C;
  localparam int AW = $clog2(T);

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [31:0]   data;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;
  logic          done;

  ofm_reader #(.M_p(M), .R_p(R), .C_p(C)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .data_o    (data),
    .valid_o   (valid),
    .ready_i   (ready),
    .last_o    (last),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: synchronous read, one cycle latency.
  logic [31:0] mem [T];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];

  // Per-run statistics gathered by the monitor.
  int run_ref, first_rd, first_vld, last_cyc, done_cyc;
  int done_run, done_total, rd_run, hs_run, exp_addr;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_run();
    logic [31:0] w;
    for (int a = 0; a < T; a++) begin
      w = 32'h3F80_0000 + 32'(a);
`ifdef OFM_RELU_EN
      if (a == 4 || a == 7) w = 32'h0000_0000;
`endif
      exp_q.push_back({(a == T - 1), w});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready follows 1,0,0,1
  task automatic wait_done(input int mode, input int limit);
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    n = 0;
    while (done_run == 0 && n < limit) begin
      @(posedge clk); #1;
      if (mode == 1) ready = pat[n % 4];
      else ready = 1'b1;
      n++;
    end
    check("done_seen", 64'(done_run != 0), 64'd1);
    ready = 1'b1;
  endtask

  task automatic check_latency(input string tag);
    check({tag, "_first_rd"}, 64'(first_rd), 64'd1);
    check({tag, "_first_vld"}, 64'(first_vld), 64'd3);
    check({tag, "_last_cyc"}, 64'(last_cyc), 64'(T + 2));
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(T + 3));
  endtask

  task automatic check_run(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_words"}, 64'(hs_run), 64'(T));
    check({tag, "_reads"}, 64'(rd_run), 64'(T));
    check({tag, "_dones"}, 64'(done_run), 64'd1);
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int a = 0; a < T; a++) mem[a] = 32'h3F80_0000 + 32'(a);
`ifdef OFM_RELU_EN
    mem[4] = 32'hC000_0000;
    mem[7] = 32'h8000_0000;
`endif
    reset_n = 1'b0;
    start   = 1'b0;
    ready   = 1'b1;
    run_ref = 0; first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
    done_run = 0; done_total = 0; rd_run = 0; hs_run = 0; exp_addr = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    fork
      // ---------------- monitor / scoreboard ----------------
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          prev_stall = 1'b0;
        end else begin
          if (start && !busy) begin
            run_ref = cyc; first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
            done_run = 0; rd_run = 0; hs_run = 0; exp_addr = 0;
          end
          if (prev_stall) begin
            check("stall_valid_held", 64'(valid), 64'd1);
            check("stall_data_held", 64'(data), 64'(prev_data));
            check("stall_last_held", 64'(last), 64'(prev_last));
          end
          if (valid && first_vld < 0) first_vld = cyc - run_ref;
          if (valid && ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: got %0h, expected no word", data);
            end else begin
              logic [32:0] e;
              e = exp_q.pop_front();
              check("word_data", 64'(data), 64'(e[31:0]));
              check("word_last", 64'(last), 64'(e[32]));
            end
            hs_run++;
            if (last) last_cyc = cyc - run_ref;
          end
          if (rd_en) begin
            check("rd_addr", 64'(rd_addr), 64'(exp_addr));
            exp_addr++;
            rd_run++;
            if (first_rd < 0) first_rd = cyc - run_ref;
            check("outstanding_le_2", 64'((rd_run - hs_run) <= 2), 64'd1);
          end
          if (done) begin
            done_run++;
            done_total++;
            done_cyc = cyc - run_ref;
          end
          prev_stall = valid && !ready;
          prev_data  = data;
          prev_last  = last;
        end
      end

      // ---------------- stimulus ----------------
      begin
        int k;
        int dt;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        reset_n = 1'b1;

        // Run 1: ready held high, latency profile.
        push_run();
        pulse_start();
        wait_done(0, 100);
        check_latency("run1");
        check_run("run1");

        // Run 2: ready toggles 1,0,0,1.
        push_run();
        pulse_start();
        wait_done(1, 200);
        check_run("run2");

        // Run 3: long stall right after start.
        push_run();
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", 64'(rd_run), 64'd2);
        ready = 1'b1;
        wait_done(0, 100);
        check_run("run3");

        // Run 4: start re-pulsed mid-run and during FIN; both ignored.
        push_run();
        @(posedge clk); #1;
        start = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < k + 5) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < k + T + 3) begin @(posedge clk); #1; end
        check("fin_cycle_done", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_run("run4");

        // Run 5: fresh start in IDLE gives an identical run.
        push_run();
        pulse_start();
        wait_done(0, 100);
        check_latency("run5");
        check_run("run5");

        // Run 6: asynchronous reset after word 5.
        push_run();
        pulse_start();
        dt = 0;
        while (hs_run < 5 && dt < 100) begin @(posedge clk); dt++; end
        check("reach_word5", 64'(hs_run >= 5), 64'd1);
        k = done_total;
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_rd_en", 64'(rd_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_total), 64'(k));
        reset_n = 1'b1;

        // Run 7: restart after abort begins at address 0.
        push_run();
        pulse_start();
        wait_done(0, 100);
        check_latency("run7");
        check_run("run7");
      end
    join_any

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
